// File: rtl/hist_eq_pkg.sv
// Shared types and widths for the histogram-equalisation frame controller.
package hist_eq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        CALC  = 2'd2
    } state_e;

    localparam int BOUND_W     = 10;
    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/hist_eq_line_cnt.sv
// Per-frame line counter. A clear together with an increment yields 1, so an
// SOF beat that also ends a line counts as line 0 done.
module hist_eq_line_cnt #(
    parameter int CNT_W = 12,
    parameter int TERM  = 479
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             term
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = inc ? CNT_W'(1) : '0;
        else if (inc)
            count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;
    assign term  = (count_q == CNT_W'(TERM));

endmodule

// File: rtl/hist_eq_frame_ctrl.sv
// Frame-level sequencer for histogram equalisation: snoops the pixel stream,
// shadows parameters per frame, and optional CALC watchdog (HIST_EQ_CTRL_TIMEOUT_EN).
module hist_eq_frame_ctrl
    import hist_eq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_HEIGHT = 480,
    parameter int LINE_CNT_W = 12
) (
    input  logic                   i_sys_clk,
    input  logic                   i_sys_aresetn,
    input  logic [DATA_WIDTH-1:0]  contrast_threshold_param,
    input  logic [BOUND_W-1:0]     upper_bound_param,
    input  logic [BOUND_W-1:0]     lower_bound_param,
    input  logic                   thresholding_en,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tuser,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    input  logic                   i_calc_done,
    output logic                   o_hist_clr,
    output logic                   o_accum_en,
    output logic                   o_calc_start,
    output logic                   o_lut_valid,
    output logic [DATA_WIDTH-1:0]  o_contrast_threshold,
    output logic [BOUND_W-1:0]     o_upper_bound,
    output logic [BOUND_W-1:0]     o_lower_bound,
    output logic                   o_thresholding_en,
    output logic                   o_frame_err,
    output logic [FRAME_CNT_W-1:0] o_frame_cnt
);

    state_e                 state_q, state_d;
    logic                   tready_q, tready_d;
    logic                   accum_en_q, accum_en_d;
    logic                   hist_clr_q, hist_clr_d;
    logic                   calc_start_q, calc_start_d;
    logic                   lut_valid_q, lut_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [DATA_WIDTH-1:0]  contrast_q, contrast_d;
    logic [BOUND_W-1:0]     upper_q, upper_d;
    logic [BOUND_W-1:0]     lower_q, lower_d;
    logic                   thr_en_q, thr_en_d;

    logic                   beat, sof, eol;
    logic                   lc_clr, lc_inc, lc_term;
    logic [LINE_CNT_W-1:0]  lc_count;
    logic                   unused_lc;

    assign beat = s_axis_tvalid & tready_q;
    assign sof  = beat & s_axis_tuser;
    assign eol  = beat & s_axis_tlast;

    // Count is exposed for debug visibility; sequencing only needs the terminal flag.
    assign unused_lc = ^lc_count;

    hist_eq_line_cnt #(
        .CNT_W (LINE_CNT_W),
        .TERM  (IMG_HEIGHT - 1)
    ) u_line_cnt (
        .clk   (i_sys_clk),
        .rst_n (i_sys_aresetn),
        .clr   (lc_clr),
        .inc   (lc_inc),
        .count (lc_count),
        .term  (lc_term)
    );

`ifdef HIST_EQ_CTRL_TIMEOUT_EN
    // 4*2^DATA_WIDTH CALC cycles: the counter saturating at all-ones marks the last one.
    logic [DATA_WIDTH+1:0] wd_q, wd_d;
    logic                  wd_expired;
    assign wd_expired = &wd_q;
`endif

    always_comb begin
        state_d      = state_q;
        hist_clr_d   = 1'b0;
        calc_start_d = 1'b0;
        frame_err_d  = 1'b0;
        lut_valid_d  = lut_valid_q;
        frame_cnt_d  = frame_cnt_q;
        contrast_d   = contrast_q;
        upper_d      = upper_q;
        lower_d      = lower_q;
        thr_en_d     = thr_en_q;
        lc_clr       = 1'b0;
        lc_inc       = 1'b0;

        if (sof && state_q != CALC) begin
            // Early SOF in ACCUM restarts the frame in place and flags the short one.
            state_d     = ACCUM;
            hist_clr_d  = 1'b1;
            frame_err_d = (state_q == ACCUM);
            contrast_d  = contrast_threshold_param;
            upper_d     = upper_bound_param;
            lower_d     = lower_bound_param;
            thr_en_d    = thresholding_en;
            lc_clr      = 1'b1;
            lc_inc      = eol;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (eol) begin
                        lc_inc = 1'b1;
                        if (lc_term) begin
                            state_d      = CALC;
                            calc_start_d = 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (i_calc_done) begin
                        state_d     = IDLE;
                        lut_valid_d = 1'b1;
                        frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                    end
`ifdef HIST_EQ_CTRL_TIMEOUT_EN
                    else if (wd_expired) begin
                        state_d     = IDLE;
                        frame_err_d = 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end

        tready_d   = (state_d != CALC);
        accum_en_d = (state_d == ACCUM);
    end

`ifdef HIST_EQ_CTRL_TIMEOUT_EN
    always_comb begin
        wd_d = '0;
        if (state_q == CALC && state_d == CALC)
            wd_d = wd_q + 1'b1;
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn)
            wd_q <= '0;
        else
            wd_q <= wd_d;
    end
`endif

    always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn) begin
            state_q      <= IDLE;
            tready_q     <= 1'b1;
            accum_en_q   <= 1'b0;
            hist_clr_q   <= 1'b0;
            calc_start_q <= 1'b0;
            lut_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_cnt_q  <= '0;
            contrast_q   <= '0;
            upper_q      <= '0;
            lower_q      <= '0;
            thr_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            tready_q     <= tready_d;
            accum_en_q   <= accum_en_d;
            hist_clr_q   <= hist_clr_d;
            calc_start_q <= calc_start_d;
            lut_valid_q  <= lut_valid_d;
            frame_err_q  <= frame_err_d;
            frame_cnt_q  <= frame_cnt_d;
            contrast_q   <= contrast_d;
            upper_q      <= upper_d;
            lower_q      <= lower_d;
            thr_en_q     <= thr_en_d;
        end
    end

    assign s_axis_tready        = tready_q;
    assign o_accum_en           = accum_en_q;
    assign o_hist_clr           = hist_clr_q;
    assign o_calc_start         = calc_start_q;
    assign o_lut_valid          = lut_valid_q;
    assign o_frame_err          = frame_err_q;
    assign o_frame_cnt          = frame_cnt_q;
    assign o_contrast_threshold = contrast_q;
    assign o_upper_bound        = upper_q;
    assign o_lower_bound        = lower_q;
    assign o_thresholding_en    = thr_en_q;

endmodule
